disp_scheduler: RTL



---
 rtl/disp_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/disp_scheduler.sv
// disp_scheduler: time-shares the 7-seg display among N_SRC byte sources (auto dwell, manual step, update pre-empt).
// Outputs registered one cycle after sel/data change; no backpressure. DISP_FLASH_EN adds a blink while pre-empted.
module disp_scheduler #(
    parameter  int N_SRC        = 4,
    parameter  int DWELL        = 50000000,
    parameter  int FLASH_PERIOD = 6250000,
    localparam int IDXW         = $clog2(N_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_hex,
    input  logic [N_SRC-1:0]   src_upd,
    input  logic               next_btn,
    input  logic               mode_btn,
    output logic [7:0]         disp_value,
    output logic               disp_hex,
    output logic               disp_enable,
    output logic [IDXW-1:0]    sel,
    output logic               auto_mode
);
    localparam int            CW       = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {ST_AUTO, ST_MANUAL, ST_PREEMPT} state_t;

    state_t          state_q;
    logic [IDXW-1:0] sel_q;
    logic [IDXW-1:0] saved_sel_q;
    logic            ret_auto_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      disp_value_q;
    logic            disp_hex_q;
    logic            disp_en_q;
    logic            auto_mode_q;

    logic            pre_hit;
    logic [IDXW-1:0] pre_idx;
    logic [IDXW-1:0] sel_inc;
    logic            dwell_done;
    logic            pre_exit;

    // Descending scan so the lowest non-displayed updating index ends up winning.
    always_comb begin
        pre_hit = 1'b0;
        pre_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_upd[i] && (IDXW'(i) != sel_q)) begin
                pre_hit = 1'b1;
                pre_idx = IDXW'(i);
            end
        end
    end

    assign sel_inc    = (sel_q == IDXW'(N_SRC - 1)) ? '0 : sel_q + IDXW'(1);
    assign dwell_done = (cnt_q == CNT_LAST);
    assign pre_exit   = (state_q == ST_PREEMPT) && (next_btn || dwell_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_AUTO;
            sel_q        <= '0;
            saved_sel_q  <= '0;
            ret_auto_q   <= 1'b1;
            cnt_q        <= '0;
            disp_value_q <= '0;
            disp_hex_q   <= 1'b0;
            auto_mode_q  <= 1'b1;
        end else begin
            disp_value_q <= src_data[{sel_q, 3'b000} +: 8];
            disp_hex_q   <= src_hex[sel_q];
            case (state_q)
                ST_AUTO, ST_MANUAL: begin
                    if (pre_hit) begin
                        saved_sel_q <= sel_q;
                        ret_auto_q  <= (state_q == ST_AUTO);
                        sel_q       <= pre_idx;
                        cnt_q       <= '0;
                        state_q     <= ST_PREEMPT;
                    end else begin
                        if (next_btn || (state_q == ST_AUTO && dwell_done))
                            sel_q <= sel_inc;
                        if (state_q == ST_AUTO && !mode_btn && !next_btn && !dwell_done)
                            cnt_q <= cnt_q + CW'(1);
                        else
                            cnt_q <= '0;
                        if (mode_btn) begin
                            state_q     <= (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
                            auto_mode_q <= (state_q != ST_AUTO);
                        end
                    end
                end
                ST_PREEMPT: begin
                    // A mode press on the exit edge still decides where we return to.
                    if (mode_btn)
                        ret_auto_q <= ~ret_auto_q;
                    auto_mode_q <= ret_auto_q ^ mode_btn;
                    if (pre_exit) begin
                        sel_q   <= saved_sel_q;
                        cnt_q   <= '0;
                        state_q <= (ret_auto_q ^ mode_btn) ? ST_AUTO : ST_MANUAL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_AUTO;
            endcase
        end
    end

`ifdef DISP_FLASH_EN
    localparam int            FW         = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_PERIOD - 1);

    logic [FW-1:0] flash_cnt_q;

    // Held at 0/on outside PREEMPT, so entry starts lit with a fresh phase and exit forces on.
    always_ff @(posedge clk) begin
        if (reset) begin
            flash_cnt_q <= '0;
            disp_en_q   <= 1'b0;
        end else if (state_q != ST_PREEMPT || pre_exit) begin
            flash_cnt_q <= '0;
            disp_en_q   <= 1'b1;
        end else if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_q <= '0;
            disp_en_q   <= ~disp_en_q;
        end else begin
            flash_cnt_q <= flash_cnt_q + FW'(1);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset)
            disp_en_q <= 1'b0;
        else
            disp_en_q <= 1'b1;
    end

    if (FLASH_PERIOD < 1) begin : g_flash_period_unused
    end
`endif

    assign disp_value  = disp_value_q;
    assign disp_hex    = disp_hex_q;
    assign disp_enable = disp_en_q;
    assign sel         = sel_q;
    assign auto_mode   = auto_mode_q;
endmodule
